// File: rtl/alu_bus_arbiter.sv
// rtl/alu_bus_arbiter.sv - round-robin two-requester front end for a shared tri-state ALU
// Optional macro ALU_OPCODE_FILTER_EN: unsupported opcodes are nacked without using the ALU.
module alu_bus_arbiter #(
  parameter int WIDTH  = 4,
  parameter int OPW    = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_data_a,
  output logic [WIDTH-1:0] alu_data_b,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_bus
`ifdef ALU_OPCODE_FILTER_EN
  ,
  output logic             nack
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRIVE, DONE} state_t;

  // Counter preload: DRIVE lasts SETTLE cycles, counting down to zero.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state;
  state_t           state_nx;
  logic             last_grant;  // also identifies the owner of the transaction in flight
  logic             grant_now;
  logic             win;
  logic             skip;
  logic [OPW-1:0]   win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [3:0]       cnt;

  // Round-robin pick: a lone request wins, a tie goes to the requester that did not win last.
  always_comb begin
    grant_now = 1'b0;
    win       = 1'b0;
    if (req0 && req1) begin
      grant_now = 1'b1;
      win       = ~last_grant;
    end else if (req0) begin
      grant_now = 1'b1;
      win       = 1'b0;
    end else if (req1) begin
      grant_now = 1'b1;
      win       = 1'b1;
    end
  end

  assign win_op = win ? op1 : op0;
  assign win_a  = win ? a1 : a0;
  assign win_b  = win ? b1 : b0;

`ifdef ALU_OPCODE_FILTER_EN
  assign skip = !((win_op == 3'b001) || (win_op == 3'b010) || (win_op == 3'b110));
`else
  assign skip = 1'b0;
`endif

  // Next-state logic for the grant / load / drive / done sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_now) state_nx = skip ? DONE : LOAD;
      LOAD:    state_nx = DRIVE;
      DRIVE:   if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset releases the ALU bus immediately since alu_enable decodes from state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  // Grant bookkeeping and ALU input registers, loaded only at grant and held otherwise.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_grant <= 1'b1;
      alu_opcode <= '0;
      alu_data_a <= '0;
      alu_data_b <= '0;
    end else if (state == IDLE && grant_now) begin
      last_grant <= win;
      alu_opcode <= win_op;
      alu_data_a <= win_a;
      alu_data_b <= win_b;
    end
  end

  // Settle counter and result capture on the final DRIVE cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt    <= 4'd0;
      result <= '0;
    end else if (state == LOAD) begin
      cnt <= SETTLE_LAST;
    end else if (state == DRIVE) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else             result <= alu_bus;
    end
  end

`ifdef ALU_OPCODE_FILTER_EN
  logic nack_q;

  // Remember whether the granted opcode was rejected so DONE can flag it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                        nack_q <= 1'b0;
    else if (state == IDLE && grant_now) nack_q <= skip;
  end

  assign nack = (state == DONE) && nack_q;
`endif

  assign alu_enable = (state == DRIVE);
  assign busy       = (state != IDLE);
  assign ack0       = (state == DONE) && !last_grant;
  assign ack1       = (state == DONE) && last_grant;

endmodule

// File: tb/tb_alu_bus_arbiter.sv
// tb/tb_alu_bus_arbiter.sv - vector-table bench for alu_bus_arbiter with a behavioural tri-state ALU
module tb_alu_bus_arbiter;

  logic       clk;
  logic       rst_b;
  logic       r0_1, r1_1, r0_3, r1_3;
  logic [2:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;

  logic       ack0_1, ack1_1, busy_1, en_1;
  logic [3:0] res_1, da_1, db_1;
  logic [2:0] opc_1;
  wire  [3:0] bus_1;
  logic       ack0_3, ack1_3, busy_3, en_3;
  logic [3:0] res_3, da_3, db_3;
  logic [2:0] opc_3;
  wire  [3:0] bus_3;
`ifdef ALU_OPCODE_FILTER_EN
  logic       nack_1, nack_3;
`endif

  int nvec = 0;
  int nerr = 0;

  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b001:  alu_f = a | b;
      3'b010:  alu_f = a ^ b;
      3'b110:  alu_f = ~b;
      default: alu_f = 4'b0000;
    endcase
  endfunction

  assign bus_1 = en_1 ? alu_f(opc_1, da_1, db_1) : 4'bzzzz;
  assign bus_3 = en_3 ? alu_f(opc_3, da_3, db_3) : 4'bzzzz;

  alu_bus_arbiter #(.WIDTH(4), .OPW(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .req0(r0_1), .req1(r1_1),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0_1), .ack1(ack1_1), .result(res_1), .busy(busy_1),
    .alu_opcode(opc_1), .alu_data_a(da_1), .alu_data_b(db_1),
    .alu_enable(en_1), .alu_bus(bus_1)
`ifdef ALU_OPCODE_FILTER_EN
    , .nack(nack_1)
`endif
  );

  alu_bus_arbiter #(.WIDTH(4), .OPW(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .req0(r0_3), .req1(r1_3),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0_3), .ack1(ack1_3), .result(res_3), .busy(busy_3),
    .alu_opcode(opc_3), .alu_data_a(da_3), .alu_data_b(db_3),
    .alu_enable(en_3), .alu_bus(bus_3)
`ifdef ALU_OPCODE_FILTER_EN
    , .nack(nack_3)
`endif
  );

  logic       use3;
  wire        ack0_m = use3 ? ack0_3 : ack0_1;
  wire        ack1_m = use3 ? ack1_3 : ack1_1;
  wire        busy_m = use3 ? busy_3 : busy_1;
  wire        en_m   = use3 ? en_3 : en_1;
  wire  [3:0] res_m  = use3 ? res_3 : res_1;
`ifdef ALU_OPCODE_FILTER_EN
  wire        nack_m = use3 ? nack_3 : nack_1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dut3;
    logic       r0, r1;
    logic [2:0] o0;
    logic [3:0] va0, vb0;
    logic [2:0] o1;
    logic [3:0] va1, vb1;
    logic       who;
    logic [3:0] res;
    logic       bad;
  } vec_t;

  vec_t       vecs[8];
  logic [3:0] last_res[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int         lat;
    int         en_cnt;
    logic       got;
    logic       busy_ok;
    int         d;
    int         settle;
    int         exp_lat;
    int         exp_en;
    logic [3:0] exp_res;
    d      = v.dut3 ? 1 : 0;
    settle = v.dut3 ? 3 : 1;
    exp_lat = 2 + settle;
    exp_en  = settle;
    exp_res = v.res;
`ifdef ALU_OPCODE_FILTER_EN
    if (v.bad) begin
      exp_lat = 1;
      exp_en  = 0;
      exp_res = last_res[d];
    end
`endif
    last_res[d] = exp_res;
    @(negedge clk);
    use3 = v.dut3;
    op0 = v.o0; a0 = v.va0; b0 = v.vb0;
    op1 = v.o1; a1 = v.va1; b1 = v.vb1;
    if (v.dut3) begin r0_3 = v.r0; r1_3 = v.r1; end
    else        begin r0_1 = v.r0; r1_1 = v.r1; end
    lat = 0; en_cnt = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (en_m) en_cnt++;
      if (!busy_m) busy_ok = 1'b0;
      if (ack0_m || ack1_m) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("ack0", 32'(ack0_m), 32'(!v.who));
    chk("ack1", 32'(ack1_m), 32'(v.who));
    chk("result", 32'(res_m), 32'(exp_res));
    chk("enable_cycles", 32'(en_cnt), 32'(exp_en));
    chk("busy_window", 32'(busy_ok), 32'd1);
`ifdef ALU_OPCODE_FILTER_EN
    chk("nack", 32'(nack_m), 32'(v.bad));
`endif
    r0_1 = 1'b0; r1_1 = 1'b0; r0_3 = 1'b0; r1_3 = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack0_m | ack1_m), 32'd0);
    chk("idle_after", 32'({busy_m, en_m}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    last_res[0] = 4'd0;
    last_res[1] = 4'd0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    int         seen;
    int         t_ack[3];
    logic       w_ack[3];
    logic [3:0] r_ack[3];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 3'b001, 4'b0101, 4'b0011, 3'b000, 4'b0000, 4'b0000, 1'b0, 4'b0111, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'b000, 4'b0000, 4'b0000, 3'b010, 4'b1100, 4'b1010, 1'b1, 4'b0110, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b011, 4'b1111, 4'b1111, 3'b000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b001, 4'b0001, 4'b0010, 3'b010, 4'b1111, 4'b0101, 1'b1, 4'b1010, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'b000, 4'b0000, 4'b0000, 3'b110, 4'b0000, 4'b0110, 1'b1, 4'b1001, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'b000, 4'b1010, 4'b0101, 3'b000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 3'b001, 4'b0101, 4'b0011, 3'b000, 4'b0000, 4'b0000, 1'b0, 4'b0111, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 3'b000, 4'b0000, 4'b0000, 3'b110, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0};

    use3 = 1'b0;
    r0_1 = 1'b0; r1_1 = 1'b0; r0_3 = 1'b0; r1_3 = 1'b0;
    op0 = 3'b000; op1 = 3'b000; a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
    last_res[0] = 4'd0;
    last_res[1] = 4'd0;
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    #2;
    chk("rst_acks", 32'({ack0_1, ack1_1}), 32'd0);
    chk("rst_busy_en", 32'({busy_1, en_1}), 32'd0);
    chk("rst_alu_regs", 32'({opc_1, da_1, db_1}), 32'd0);
    chk("rst_result", 32'(res_1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // Both requesters held: grants alternate 0,1,0 every four cycles.
    do_reset();
    @(negedge clk);
    use3 = 1'b0;
    op0 = 3'b110; a0 = 4'b0000; b0 = 4'b0011;
    op1 = 3'b001; a1 = 4'b1000; b1 = 4'b0001;
    r0_1 = 1'b1; r1_1 = 1'b1;
    seen = 0;
    for (int c = 1; c <= 40 && seen < 3; c++) begin
      @(posedge clk); #1;
      if (ack0_1 || ack1_1) begin
        t_ack[seen] = c;
        w_ack[seen] = ack1_1;
        r_ack[seen] = res_1;
        seen++;
      end
    end
    r0_1 = 1'b0; r1_1 = 1'b0;
    chk("fair_count", 32'(seen), 32'd3);
    if (seen == 3) begin
      chk("fair_who0", 32'(w_ack[0]), 32'd0);
      chk("fair_who1", 32'(w_ack[1]), 32'd1);
      chk("fair_who2", 32'(w_ack[2]), 32'd0);
      chk("fair_res0", 32'(r_ack[0]), 32'hC);
      chk("fair_res1", 32'(r_ack[1]), 32'h9);
      chk("fair_res2", 32'(r_ack[2]), 32'hC);
      chk("fair_t0", 32'(t_ack[0]), 32'd3);
      chk("fair_gap", 32'(t_ack[2] - t_ack[1]), 32'd4);
    end
    @(posedge clk); #1;
    last_res[0] = 4'hC;

    // Reset pulsed during DRIVE: bus released without a clock edge, no ack.
    @(negedge clk);
    op0 = 3'b010; a0 = 4'b0011; b0 = 4'b0101;
    r0_1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_drive_en", 32'(en_1), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_en", 32'(en_1), 32'd0);
    chk("mid_rst_busy", 32'(busy_1), 32'd0);
    chk("mid_rst_result", 32'(res_1), 32'd0);
    r0_1 = 1'b0;
    last_res[0] = 4'd0;
    last_res[1] = 4'd0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ack0_1 || ack1_1) seen++;
    end
    chk("mid_rst_no_ack", 32'(seen), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    run(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
